// File: rtl/volume_pkg.sv
`default_nettype none
// ============================================================================
// Module      : volume_pkg
// Description : Shared default constants and level type for the volume path.
// Revision    : 1.0 - initial release
// ============================================================================
package volume_pkg;

  localparam int DEF_LEVEL_W     = 4;
  localparam int DEF_MAX_LEVEL   = 15;
  localparam int DEF_INIT_LEVEL  = 8;
  localparam int DEF_RAMP_CYCLES = 4;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

endpackage : volume_pkg
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen
// Description : Free-running PWM. A counter sweeps 0..MAX_LEVEL-1 and the
//               registered output is high while duty > counter, giving exactly
//               duty high cycles per MAX_LEVEL-cycle period.
// Ports       : clk      - system clock
//               n_reset  - asynchronous active-low reset
//               duty     - high cycles per period (0..MAX_LEVEL)
//               pwm_out  - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
  parameter int LEVEL_W   = 4,
  parameter int MAX_LEVEL = 15
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [LEVEL_W-1:0] duty,
  output logic               pwm_out
);

  // MAX_LEVEL <= 2**LEVEL_W-1, so the period counter fits in LEVEL_W bits.
  localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'(MAX_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] CNT_ONE  = LEVEL_W'(1);

  logic [LEVEL_W-1:0] cnt_q, cnt_d;
  logic               pwm_q, pwm_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    pwm_d = (duty > cnt_q);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule : pwm_gen
`default_nettype wire

// File: rtl/volume_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : volume_level_ctrl
// Description : Saturating volume level with mute, a prescaled ramp of the
//               applied level toward its target, PWM and thermometer bar.
// Ports       : clk, n_reset              - clock, async active-low reset
//               increment/decrement       - single-cycle target +1 / -1
//               mute_toggle               - single-cycle mute inversion
//               level, eff_level          - target and ramped levels
//               muted, at_max, at_min     - status
//               changed                   - one-cycle pulse on level change
//               pwm_out                   - PWM, duty eff_level/MAX_LEVEL
//               bar                       - thermometer code of eff_level
// Revision    : 1.0 - initial release
// ============================================================================
module volume_level_ctrl
  import volume_pkg::*;
#(
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int INIT_LEVEL  = DEF_INIT_LEVEL,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 increment,
  input  logic                 decrement,
  input  logic                 mute_toggle,
  output logic [LEVEL_W-1:0]   level,
  output logic [LEVEL_W-1:0]   eff_level,
  output logic                 muted,
  output logic                 at_max,
  output logic                 at_min,
  output logic                 changed,
  output logic                 pwm_out,
  output logic [MAX_LEVEL-1:0] bar
);

  localparam int                 PRE_W    = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] INIT_L   = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(RAMP_CYCLES - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] eff_q, eff_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               muted_q, muted_d;
  logic               changed_q, changed_d;
  logic [LEVEL_W-1:0] ramp_tgt;
  logic               ramp_tick;

  // Target level: simultaneous inc/dec cancel; both ends saturate.
  always_comb begin
    level_d = level_q;
    if (increment && !decrement && (level_q != MAX_L)) begin
      level_d = level_q + LVL_ONE;
    end else if (decrement && !increment && (level_q != '0)) begin
      level_d = level_q - LVL_ONE;
    end
    changed_d = (level_d != level_q);
    muted_d   = muted_q ^ mute_toggle;
  end

  // Ramp uses the registered target, so a mid-ramp change is picked up at
  // the next step; single-unit steps cannot overshoot.
  always_comb begin
    ramp_tgt  = muted_q ? '0 : level_q;
    ramp_tick = (pre_q == PRE_LAST);
    pre_d     = ramp_tick ? '0 : pre_q + PRE_ONE;
    eff_d     = eff_q;
    if (ramp_tick) begin
      if (eff_q < ramp_tgt) begin
        eff_d = eff_q + LVL_ONE;
      end else if (eff_q > ramp_tgt) begin
        eff_d = eff_q - LVL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      level_q   <= INIT_L;
      eff_q     <= '0;
      pre_q     <= '0;
      muted_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      eff_q     <= eff_d;
      pre_q     <= pre_d;
      muted_q   <= muted_d;
      changed_q <= changed_d;
    end
  end

  pwm_gen #(
    .LEVEL_W   (LEVEL_W),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_pwm_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .duty    (eff_q),
    .pwm_out (pwm_out)
  );

  for (genvar i = 0; i < MAX_LEVEL; i++) begin : g_bar
    assign bar[i] = (eff_q > LEVEL_W'(i));
  end

  assign level     = level_q;
  assign eff_level = eff_q;
  assign muted     = muted_q;
  assign changed   = changed_q;
  assign at_max    = (level_q == MAX_L);
  assign at_min    = (level_q == '0);

endmodule : volume_level_ctrl
`default_nettype wire
